// File: rtl/intersection_sequencer.sv
// Phase-handshake initiator: alternates vehicle and pedestrian responders with an all-red gap,
// latches pedestrian requests and trips a watchdog on stalled handshakes.
module intersection_sequencer #(
  parameter int DIV_FACTOR  = 10,
  parameter int SECUNDE_GAP = 2,
  parameter int TIMEOUT_SEC = 40
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       buton_pieton,
  input  logic       auto_done,
  input  logic       ped_done,
  output logic       auto_enable,
  output logic       auto_clear,
  output logic       ped_enable,
  output logic       ped_clear,
  output logic       rosu_total,
  output logic       cerere_pieton,
  output logic       eroare,
  output logic [1:0] faza
);

  localparam int SEC_MAX = (SECUNDE_GAP > TIMEOUT_SEC) ? SECUNDE_GAP : TIMEOUT_SEC;
  localparam int PW      = (DIV_FACTOR > 1) ? $clog2(DIV_FACTOR) : 1;
  localparam int SW      = $clog2(SEC_MAX + 1);

  typedef enum logic [2:0] {
    IDLE, AUTO_REQ, AUTO_CLR, GAP_A, PED_REQ, PED_CLR, GAP_P, ERR
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [PW-1:0]   r_presc;
  logic [SW-1:0]   r_sec;
  logic            r_btnPrev;
  logic            w_tick;
  logic            w_counting;
  logic            w_gapEnd;
  logic            w_timeout;
  logic            w_reqSet;
  logic            w_reqClr;

  assign w_tick     = (r_presc == PW'(DIV_FACTOR - 1));
  assign w_counting = (r_state != IDLE) && (r_state != ERR);
  assign w_gapEnd   = w_tick && (r_sec == SW'(SECUNDE_GAP - 1));
  assign w_timeout  = w_tick && (r_sec == SW'(TIMEOUT_SEC - 1));

  // A completed handshake takes priority over a watchdog expiry landing on the same edge.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (run) w_next = AUTO_REQ;
      AUTO_REQ: if (auto_done) w_next = AUTO_CLR;
                else if (w_timeout) w_next = ERR;
      AUTO_CLR: if (!auto_done) w_next = GAP_A;
                else if (w_timeout) w_next = ERR;
      GAP_A:    if (w_gapEnd) begin
                  if (!run) w_next = IDLE;
                  else if (cerere_pieton) w_next = PED_REQ;
                  else w_next = AUTO_REQ;
                end
      PED_REQ:  if (ped_done) w_next = PED_CLR;
                else if (w_timeout) w_next = ERR;
      PED_CLR:  if (!ped_done) w_next = GAP_P;
                else if (w_timeout) w_next = ERR;
      GAP_P:    if (w_gapEnd) w_next = run ? AUTO_REQ : IDLE;
      ERR:      if (!run) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  assign w_reqSet = buton_pieton && !r_btnPrev && (r_state != PED_REQ);
  assign w_reqClr = (w_next == PED_REQ) && (r_state != PED_REQ);

  // Outputs are decoded from the next state so they are registered yet still Moore.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_presc       <= '0;
      r_sec         <= '0;
      r_btnPrev     <= 1'b0;
      cerere_pieton <= 1'b0;
      auto_enable   <= 1'b0;
      auto_clear    <= 1'b0;
      ped_enable    <= 1'b0;
      ped_clear     <= 1'b0;
      rosu_total    <= 1'b1;
      eroare        <= 1'b0;
      faza          <= 2'd0;
    end else begin
      r_state   <= w_next;
      r_btnPrev <= buton_pieton;

      if ((w_next != r_state) || !w_counting) begin
        r_presc <= '0;
        r_sec   <= '0;
      end else if (w_tick) begin
        r_presc <= '0;
        r_sec   <= r_sec + SW'(1);
      end else begin
        r_presc <= r_presc + PW'(1);
      end

      if (w_reqClr)      cerere_pieton <= 1'b0;
      else if (w_reqSet) cerere_pieton <= 1'b1;

      auto_enable <= (w_next == AUTO_REQ);
      auto_clear  <= (w_next == AUTO_CLR);
      ped_enable  <= (w_next == PED_REQ);
      ped_clear   <= (w_next == PED_CLR);
      rosu_total  <= (w_next == IDLE) || (w_next == GAP_A) || (w_next == GAP_P) || (w_next == ERR);
      eroare      <= (w_next == ERR);
      case (w_next)
        AUTO_REQ, AUTO_CLR: faza <= 2'd1;
        PED_REQ, PED_CLR:   faza <= 2'd2;
        ERR:                faza <= 2'd3;
        default:            faza <= 2'd0;
      endcase
    end
  end

endmodule
